// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file writeback queue.
package regfile_writeback_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         WB_DEPTH = 4;

    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending writebacks; exposes its entries and per-slot
// valid bits so the parent can compare them against decode read addresses.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  wb_entry_t                    din,
    output wb_entry_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output wb_entry_t [DEPTH-1:0]        entries,
    output logic [DEPTH-1:0]             valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    wb_entry_t [DEPTH-1:0] mem;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];
    assign entries = mem;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (do_pop) begin
                rptr        <= rptr + 1'b1;
                valid[rptr] <= 1'b0;
            end
            if (do_push) begin
                wptr        <= wptr + 1'b1;
                valid[wptr] <= 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload storage is left uncleared; only the valid state is reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback queue in front of the register file: drops r0 writes, commits in
// order whenever the port is free, and flags decode reads of pending registers.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4:0]             req_reg,
    input  logic [31:0]            req_data,
    input  logic                   wb_hold,
    input  logic [4:0]             rr1,
    input  logic [4:0]             rr2,
    output logic                   rt_hazard,
    output logic                   rs_hazard,
    output logic                   wren,
    output logic [4:0]             wr,
    output logic [31:0]            wd,
    output logic [$clog2(DEPTH):0] count
);

    wb_entry_t             din;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic                  full;
    logic                  empty;
    logic                  push;

    assign req_ready = !full;
    assign push      = req_valid && req_ready && (req_reg != REG_ZERO);
    assign din       = '{wreg: req_reg, data: req_data};

    assign wren = !empty && !wb_hold;
    assign wr   = empty ? '0 : head.wreg;
    assign wd   = empty ? '0 : head.data;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (wren),
        .din     (din),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .entries (entries),
        .valid   (valid)
    );

    always_comb begin
        rt_hazard = 1'b0;
        rs_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (rr1 != REG_ZERO) && (entries[i].wreg == rr1)) begin
                rt_hazard = 1'b1;
            end
            if (valid[i] && (rr2 != REG_ZERO) && (entries[i].wreg == rr2)) begin
                rs_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue model.
module tb_regfile_writeback;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [4:0]    req_reg = '0;
    logic [31:0]   req_data = '0;
    logic          wb_hold = 1'b0;
    logic [4:0]    rr1 = '0;
    logic [4:0]    rr2 = '0;
    logic          rt_hazard;
    logic          rs_hazard;
    logic          wren;
    logic [4:0]    wr;
    logic [31:0]   wd;
    logic [CW-1:0] count;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } item_t;

    item_t mq[$];
    item_t mdl_log[$];
    item_t dut_log[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .wb_hold   (wb_hold),
        .rr1       (rr1),
        .rr2       (rr2),
        .rt_hazard (rt_hazard),
        .rs_hazard (rs_hazard),
        .wren      (wren),
        .wr        (wr),
        .wd        (wd),
        .count     (count)
    );

    function automatic bit m_haz(logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].r == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: decide accept/commit from the model, advance to next negedge.
    task automatic tick();
        bit    acc;
        bit    pop;
        item_t it;
        #1;
        acc = req_valid && (mq.size() < DEPTH);
        pop = (mq.size() != 0) && !wb_hold;
        if (wren) dut_log.push_back('{r: wr, d: wd});
        @(posedge clk);
        if (pop) begin
            it = mq.pop_front();
            mdl_log.push_back(it);
        end
        if (acc && req_reg != 5'd0) mq.push_back('{r: req_reg, d: req_data});
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", wren); end
        total++; if (wr !== 5'd0 || wd !== 32'd0) begin bad++; $display("FAIL reset_wr_wd got=%0d/%h exp=0/0", wr, wd); end
        total++; if (rt_hazard !== 1'b0 || rs_hazard !== 1'b0) begin bad++; $display("FAIL reset_haz got=%b%b exp=00", rt_hazard, rs_hazard); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_write();
        req_valid = 1'b1; req_reg = 5'd5; req_data = 32'hDEADBEEF;
        tick();
        req_valid = 1'b0;
        #1;
        total++; if (wren !== 1'b1 || wr !== 5'd5 || wd !== 32'hDEADBEEF)
            begin bad++; $display("FAIL single_commit got=%b/%0d/%h exp=1/5/deadbeef", wren, wr, wd); end
        total++; if (count !== CW'(1)) begin bad++; $display("FAIL single_count1 got=%0d exp=1", count); end
        tick();
        #1;
        total++; if (count !== '0 || wren !== 1'b0 || wr !== 5'd0 || wd !== 32'd0)
            begin bad++; $display("FAIL single_drain got=%0d/%b/%0d/%h exp=0/0/0/0", count, wren, wr, wd); end
    endtask

    task automatic test_zero_reg();
        int wren_seen = 0;
        req_valid = 1'b1; req_reg = 5'd0; req_data = 32'h12345678;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", req_ready); end
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (wren) wren_seen++;
            total++; if (count !== '0) begin bad++; $display("FAIL zero_count got=%0d exp=0", count); end
            tick();
        end
        total++; if (wren_seen != 0) begin bad++; $display("FAIL zero_wren got=%0d exp=0", wren_seen); end
    endtask

    task automatic test_fill_hold();
        wb_hold = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            req_valid = 1'b1; req_reg = 5'(r); req_data = 32'h100 + 32'(r);
            tick();
        end
        #1;
        total++; if (count !== CW'(4) || req_ready !== 1'b0)
            begin bad++; $display("FAIL fill_full got=%0d/%b exp=4/0", count, req_ready); end
        req_reg = 5'd9; req_data = 32'h999;
        tick();
        req_valid = 1'b0;
        #1;
        total++; if (count !== CW'(4)) begin bad++; $display("FAIL fill_fifth got=%0d exp=4", count); end
        wb_hold = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            #1;
            total++; if (wren !== 1'b1 || wr !== 5'(r) || wd !== 32'h100 + 32'(r))
                begin bad++; $display("FAIL fill_order got=%b/%0d/%h exp=1/%0d/%h", wren, wr, wd, r, 32'h100 + 32'(r)); end
            tick();
        end
        #1;
        total++; if (count !== '0) begin bad++; $display("FAIL fill_drain got=%0d exp=0", count); end
    endtask

    task automatic test_hazard_order();
        wb_hold = 1'b1; rr1 = 5'd7; rr2 = 5'd0;
        req_valid = 1'b1; req_reg = 5'd7; req_data = 32'd1;
        tick();
        req_data = 32'd2;
        tick();
        req_valid = 1'b0;
        #1;
        total++; if (rt_hazard !== 1'b1 || rs_hazard !== 1'b0)
            begin bad++; $display("FAIL haz_held got=%b%b exp=10", rt_hazard, rs_hazard); end
        rr2 = 5'd7;
        #1;
        total++; if (rs_hazard !== 1'b1) begin bad++; $display("FAIL haz_rs got=%b exp=1", rs_hazard); end
        rr2 = 5'd0;
        wb_hold = 1'b0;
        #1;
        total++; if (wren !== 1'b1 || wr !== 5'd7 || wd !== 32'd1)
            begin bad++; $display("FAIL haz_first got=%b/%0d/%0d exp=1/7/1", wren, wr, wd); end
        tick();
        #1;
        total++; if (wren !== 1'b1 || wd !== 32'd2 || rt_hazard !== 1'b1)
            begin bad++; $display("FAIL haz_second got=%b/%0d/%b exp=1/2/1", wren, wd, rt_hazard); end
        tick();
        #1;
        total++; if (rt_hazard !== 1'b0 || count !== '0)
            begin bad++; $display("FAIL haz_clear got=%b/%0d exp=0/0", rt_hazard, count); end
        rr1 = 5'd0;
    endtask

    task automatic test_push_pop_wrap();
        item_t sent[$];
        dut_log.delete();
        wb_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_reg = 5'((i % 31) + 1); req_data = $urandom;
            sent.push_back('{r: req_reg, d: req_data});
            tick();
            #1;
            total++; if (count !== CW'(1)) begin bad++; $display("FAIL wrap_count i=%0d got=%0d exp=1", i, count); end
        end
        req_valid = 1'b0;
        tick();
        #1;
        total++; if (count !== '0) begin bad++; $display("FAIL wrap_drain got=%0d exp=0", count); end
        total++; if (dut_log.size() != 10) begin bad++; $display("FAIL wrap_ncommit got=%0d exp=10", dut_log.size()); end
        for (int i = 0; i < 10 && i < dut_log.size(); i++) begin
            total++; if (dut_log[i].r !== sent[i].r || dut_log[i].d !== sent[i].d)
                begin bad++; $display("FAIL wrap_item i=%0d got=%0d/%h exp=%0d/%h", i, dut_log[i].r, dut_log[i].d, sent[i].r, sent[i].d); end
        end
    endtask

    task automatic test_async_reset();
        wb_hold = 1'b1; rr1 = 5'd3; rr2 = 5'd2;
        for (int r = 1; r <= 3; r++) begin
            req_valid = 1'b1; req_reg = 5'(r); req_data = 32'hA0 + 32'(r);
            tick();
        end
        req_valid = 1'b0;
        #1;
        total++; if (count !== CW'(3) || rt_hazard !== 1'b1 || rs_hazard !== 1'b1)
            begin bad++; $display("FAIL areset_pre got=%0d/%b%b exp=3/11", count, rt_hazard, rs_hazard); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (count !== '0 || wren !== 1'b0 || rt_hazard !== 1'b0 || rs_hazard !== 1'b0 || wr !== 5'd0 || req_ready !== 1'b1)
            begin bad++; $display("FAIL areset_now got=%0d/%b/%b%b/%0d/%b exp=0/0/00/0/1", count, wren, rt_hazard, rs_hazard, wr, req_ready); end
        mq.delete();
        @(negedge clk);
        rst = 1'b1; wb_hold = 1'b0;
        dut_log.delete();
        for (int i = 0; i < 4; i++) tick();
        total++; if (dut_log.size() != 0) begin bad++; $display("FAIL areset_commits got=%0d exp=0", dut_log.size()); end
        rr1 = 5'd0; rr2 = 5'd0;
    endtask

    task automatic test_random();
        mq.delete(); mdl_log.delete(); dut_log.delete();
        for (int n = 0; n < 400; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_reg   = 5'($urandom_range(0, 7));
            req_data  = $urandom;
            wb_hold   = ($urandom_range(0, 9) < 3);
            rr1       = 5'($urandom_range(0, 7));
            rr2       = 5'($urandom_range(0, 7));
            #1;
            total++; if (count !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, mq.size()); end
            total++; if (req_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, mq.size() < DEPTH); end
            total++; if (wren !== (mq.size() != 0 && !wb_hold)) begin bad++; $display("FAIL rnd_wren n=%0d got=%b", n, wren); end
            total++; if (wr !== (mq.size() != 0 ? mq[0].r : 5'd0) || wd !== (mq.size() != 0 ? mq[0].d : 32'd0))
                begin bad++; $display("FAIL rnd_head n=%0d got=%0d/%h", n, wr, wd); end
            total++; if (rt_hazard !== m_haz(rr1)) begin bad++; $display("FAIL rnd_rt n=%0d got=%b exp=%b", n, rt_hazard, m_haz(rr1)); end
            total++; if (rs_hazard !== m_haz(rr2)) begin bad++; $display("FAIL rnd_rs n=%0d got=%b exp=%b", n, rs_hazard, m_haz(rr2)); end
            tick();
        end
        req_valid = 1'b0; wb_hold = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        total++; if (dut_log.size() != mdl_log.size()) begin bad++; $display("FAIL rnd_ncommit got=%0d exp=%0d", dut_log.size(), mdl_log.size()); end
        for (int i = 0; i < dut_log.size() && i < mdl_log.size(); i++) begin
            total++; if (dut_log[i].r !== mdl_log[i].r || dut_log[i].d !== mdl_log[i].d)
                begin bad++; $display("FAIL rnd_commit i=%0d got=%0d/%h exp=%0d/%h", i, dut_log[i].r, dut_log[i].d, mdl_log[i].r, mdl_log[i].d); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_zero_reg();
        test_fill_hold();
        test_hazard_order();
        test_push_pop_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
